// File: rtl/keypad_pkg.sv
// Shared constants, state/class enums and the frame classifier for the
// 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_t;

  typedef struct packed {
    frame_class_t      cls;
    logic [KEY_W-1:0]  code;
  } frame_info_t;

  // pressed[i] = 1 means key with code i (row*4+col) is down in this frame.
  // The hit counter saturates at 2 since only none/one/many matters.
  function automatic frame_info_t classify_frame(input logic [ROWS*COLS-1:0] pressed);
    frame_info_t info;
    logic [1:0]  hits;
    info.cls  = NONE;
    info.code = {KEY_W{1'b0}};
    hits      = 2'd0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (pressed[i]) begin
        if (hits == 2'd0) begin
          info.code = KEY_W'(i);
        end else begin
          info.code = info.code;
        end
        if (hits != 2'd2) begin
          hits = hits + 2'd1;
        end else begin
          hits = hits;
        end
      end else begin
        hits = hits;
      end
    end
    case (hits)
      2'd0:    info.cls = NONE;
      2'd1:    info.cls = SINGLE;
      default: info.cls = MULTI;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column scan timing: dwell divider, one-cold column drive, column tick and
// end-of-frame strobe.
module keypad_col_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [COLS-1:0] col_out,
  output logic [1:0]      col_idx,
  output logic            col_tick,
  output logic            frame_end
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign col_tick  = (div_cnt == DIV_LAST);
  assign frame_end = col_tick && (col_idx == 2'd3);

  // Dwell counter and column rotation; col_out is kept registered alongside
  // col_idx so the drive moves on the cycle after the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= {DIV_W{1'b0}};
      col_idx <= 2'd0;
      col_out <= 4'b1110;
    end else if (col_tick) begin
      div_cnt <= {DIV_W{1'b0}};
      col_idx <= col_idx + 2'd1;
      col_out <= {col_out[COLS-2:0], col_out[COLS-1]};
    end else begin
      div_cnt <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad reader: synchronises rows, builds a whole-frame snapshot,
// classifies it and debounces press/release over consecutive frames.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_release,
  output logic             key_down
);

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_FRAMES);

  logic [ROWS-1:0]      row_meta;
  logic [ROWS-1:0]      row_sync;
  logic [1:0]           col_idx;
  logic                 col_tick;
  logic                 frame_end;
  logic [ROWS*COLS-1:0] snap;
  logic [ROWS*COLS-1:0] frame_bits;
  frame_info_t          info;

  state_t           state, state_nxt;
  logic [KEY_W-1:0] cand, cand_nxt;
  logic [3:0]       deb_cnt, deb_nxt, deb_inc;
  logic [KEY_W-1:0] code_nxt;
  logic             down_nxt, valid_nxt, release_nxt;

  keypad_col_driver #(.SCAN_DIV(SCAN_DIV)) u_col_driver (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_out   (col_out),
    .col_idx   (col_idx),
    .col_tick  (col_tick),
    .frame_end (frame_end)
  );

  // Two-stage synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Snapshot with the current column's rows merged in, so the frame_end
  // classification sees all four columns.
  always_comb begin
    frame_bits = snap;
    for (int r = 0; r < ROWS; r++) begin
      frame_bits[{2'(r), col_idx}] = row_sync[r];
    end
  end

  assign info    = classify_frame(~frame_bits);
  assign deb_inc = deb_cnt + 4'd1;

  // Frame snapshot (1 = released); cleared after each frame is classified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= {(ROWS*COLS){1'b1}};
    end else if (frame_end) begin
      snap <= {(ROWS*COLS){1'b1}};
    end else if (col_tick) begin
      snap <= frame_bits;
    end else begin
      snap <= snap;
    end
  end

  // Debounce FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= {KEY_W{1'b0}};
      deb_cnt     <= 4'd0;
      key_code    <= {KEY_W{1'b0}};
      key_down    <= 1'b0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      deb_cnt     <= deb_nxt;
      key_code    <= code_nxt;
      key_down    <= down_nxt;
      key_valid   <= valid_nxt;
      key_release <= release_nxt;
    end
  end

  // Next-state logic; the FSM only moves on frame_end.
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    deb_nxt     = deb_cnt;
    code_nxt    = key_code;
    down_nxt    = key_down;
    valid_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (info.cls == SINGLE) begin
            if (DEB_TARGET <= 4'd1) begin
              code_nxt  = info.code;
              down_nxt  = 1'b1;
              valid_nxt = 1'b1;
              deb_nxt   = 4'd0;
              state_nxt = PRESSED;
            end else begin
              cand_nxt  = info.code;
              deb_nxt   = 4'd1;
              state_nxt = DEB_PRESS;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        DEB_PRESS: begin
          if (info.cls == SINGLE && info.code == cand) begin
            if (deb_inc >= DEB_TARGET) begin
              code_nxt  = cand;
              down_nxt  = 1'b1;
              valid_nxt = 1'b1;
              deb_nxt   = 4'd0;
              state_nxt = PRESSED;
            end else begin
              deb_nxt = deb_inc;
            end
          end else if (info.cls == SINGLE) begin
            cand_nxt = info.code;
            deb_nxt  = 4'd1;
          end else begin
            deb_nxt   = 4'd0;
            state_nxt = IDLE;
          end
        end
        PRESSED: begin
          if (info.cls == NONE) begin
            if (DEB_TARGET <= 4'd1) begin
              down_nxt    = 1'b0;
              release_nxt = 1'b1;
              deb_nxt     = 4'd0;
              state_nxt   = IDLE;
            end else begin
              deb_nxt   = 4'd1;
              state_nxt = DEB_REL;
            end
          end else begin
            state_nxt = PRESSED;
          end
        end
        DEB_REL: begin
          if (info.cls == NONE) begin
            if (deb_inc >= DEB_TARGET) begin
              down_nxt    = 1'b0;
              release_nxt = 1'b1;
              deb_nxt     = 4'd0;
              state_nxt   = IDLE;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            deb_nxt   = 4'd0;
            state_nxt = PRESSED;
          end
        end
        default: begin
          state_nxt = IDLE;
          deb_nxt   = 4'd0;
          down_nxt  = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a keypad matrix model and a
// cycle-exact scoreboard of expected key_valid/key_release pulses.
module tb_keypad_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_down;

  logic [15:0] keys;
  int          cyc;
  int          checks;
  int          failures;

  typedef struct {
    bit         rel;
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_down    (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: row r pulled low while column c is driven and key (r,c) held.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Pulse monitor: every pulse must match the next expected event exactly.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (key_valid === 1'b1 || key_release === 1'b1)) begin
      checks++;
      if (key_valid === 1'b1 && key_release === 1'b1) begin
        failures++;
        $display("FAIL pulse_overlap: valid and release both high at cyc=%0d", cyc);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: valid=%0b release=%0b code=%h cyc=%0d, none expected",
                 key_valid, key_release, key_code, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (key_release !== mon_e.rel || key_code !== mon_e.code || cyc !== mon_e.cyc) begin
          failures++;
          $display("FAIL pulse_event: got release=%0b code=%h cyc=%0d, expected release=%0b code=%h cyc=%0d",
                   key_release, key_code, cyc, mon_e.rel, mon_e.code, mon_e.cyc);
        end
      end
    end
  end

  task automatic push(input bit rel, input logic [3:0] code, input int frames);
    exp_t e;
    e.rel  = rel;
    e.code = code;
    e.cyc  = cyc + frames * 16;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [15:0] k, input int frames);
    keys = k;
    repeat (frames * 16) @(negedge clk);
  endtask

  // Align to the first negedge of a frame (column 0 just driven).
  task automatic sync_frame();
    logic [3:0] prev;
    prev = col_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110 && prev == 4'b0111) return;
      prev = col_out;
    end
    checks++;
    failures++;
    $display("FAIL sync_frame: no frame start within 40 cycles, col_out=%b", col_out);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col[4];
    exp_col[0] = 4'b1110;
    exp_col[1] = 4'b1101;
    exp_col[2] = 4'b1011;
    exp_col[3] = 4'b0111;
    rst_n = 1'b0;
    keys  = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({col_out, key_code, key_valid, key_release, key_down} !== {4'b1110, 4'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset_values: col=%b code=%h v=%b r=%b d=%b, expected 1110/0/0/0/0",
               col_out, key_code, key_valid, key_release, key_down);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({col_out, key_code, key_valid, key_release, key_down} !== {4'b1110, 4'h0, 3'b000}) begin
      failures++;
      $display("FAIL async_reset: col=%b code=%h v=%b r=%b d=%b, expected 1110/0/0/0/0",
               col_out, key_code, key_valid, key_release, key_down);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) @(negedge clk);
      else repeat (4) @(negedge clk);
      checks++;
      if (col_out !== exp_col[k]) begin
        failures++;
        $display("FAIL col_step%0d: col_out=%b, expected %b", k, col_out, exp_col[k]);
      end
    end
  endtask

  task automatic test_clean_press();
    sync_frame();
    push(1'b0, 4'h9, 3);
    hold(16'h0200, 6);
    checks++;
    if (key_down !== 1'b1 || key_code !== 4'h9) begin
      failures++;
      $display("FAIL clean_held: down=%b code=%h, expected 1/9", key_down, key_code);
    end
    push(1'b1, 4'h9, 3);
    hold(16'h0000, 3);
    checks++;
    if (key_down !== 1'b0) begin
      failures++;
      $display("FAIL clean_released: down=%b, expected 0", key_down);
    end
  endtask

  task automatic test_bounce();
    sync_frame();
    hold(16'h0008, 2);
    hold(16'h0000, 1);
    push(1'b0, 4'h3, 3);
    hold(16'h0008, 3);
    checks++;
    if (key_down !== 1'b1 || key_code !== 4'h3) begin
      failures++;
      $display("FAIL bounce_held: down=%b code=%h, expected 1/3", key_down, key_code);
    end
    push(1'b1, 4'h3, 3);
    hold(16'h0000, 3);
  endtask

  task automatic test_multi();
    sync_frame();
    hold(16'h4020, 3);
    checks++;
    if (key_down !== 1'b0) begin
      failures++;
      $display("FAIL multi_ignored: down=%b, expected 0", key_down);
    end
    push(1'b0, 4'h5, 3);
    hold(16'h0020, 3);
    push(1'b1, 4'h5, 3);
    hold(16'h0000, 3);
  endtask

  task automatic test_rollover();
    sync_frame();
    push(1'b0, 4'h0, 3);
    hold(16'h0001, 3);
    hold(16'h0401, 2);
    hold(16'h0400, 4);
    checks++;
    if (key_down !== 1'b1 || key_code !== 4'h0) begin
      failures++;
      $display("FAIL rollover_hold: down=%b code=%h, expected 1/0", key_down, key_code);
    end
    push(1'b1, 4'h0, 3);
    hold(16'h0000, 3);
  endtask

  task automatic test_reset_debounce();
    sync_frame();
    hold(16'h8000, 2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || key_down !== 1'b0 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: col=%b down=%b valid=%b, expected 1110/0/0",
               col_out, key_down, key_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b0, 4'hF, 3);
    hold(16'h8000, 3);
    checks++;
    if (key_down !== 1'b1 || key_code !== 4'hF) begin
      failures++;
      $display("FAIL reset_deb_held: down=%b code=%h, expected 1/f", key_down, key_code);
    end
    push(1'b1, 4'hF, 3);
    hold(16'h0000, 3);
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    keys     = 16'h0000;
    rst_n    = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_rollover();
    test_reset_debounce();
    repeat (32) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
